// File: rtl/pc_gen.sv
// pc_gen: program-counter generation with redirect, trap vectoring and fault parking.
module pc_gen #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0200,
   parameter int          DEPTH     = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        trap_req,
   output logic [31:0] pc,
   output logic        pc_valid,
   output logic [31:0] epc,
   output logic [31:0] fault_addr,
   output logic [1:0]  err_code
);
   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   localparam logic [31:0] PC_LIMIT = 32'(DEPTH) << 2;
   localparam logic [31:0] PC_LAST  = PC_LIMIT - 32'd4;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, epc_q, epc_d, fault_addr_q, fault_addr_d;
   logic        pc_valid_q, pc_valid_d;
   logic [1:0]  err_code_q, err_code_d;
   logic        tgt_misaligned, tgt_out_of_range;

   assign tgt_misaligned   = redirect_target[1:0] != 2'b00;
   assign tgt_out_of_range = redirect_target >= PC_LIMIT;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc_valid_d   = pc_valid_q;
      epc_d        = epc_q;
      fault_addr_d = fault_addr_q;
      err_code_d   = err_code_q;
      case (state_q)
         BOOT: begin
            state_d    = RUN;
            pc_valid_d = 1'b1;
         end
         RUN: begin
            if (trap_req) begin
               epc_d = pc_q;
               pc_d  = TRAP_VEC;
            end else if (redirect_valid) begin
               if (tgt_misaligned || tgt_out_of_range) begin
                  state_d      = FAULT;
                  err_code_d   = tgt_misaligned ? 2'b01 : 2'b10;
                  fault_addr_d = redirect_target;
                  pc_valid_d   = 1'b0;
               end else begin
                  pc_d = redirect_target;
               end
            end else if (!stall) begin
               // Running off the end of memory faults instead of wrapping.
               if (pc_q == PC_LAST) begin
                  state_d      = FAULT;
                  err_code_d   = 2'b10;
                  fault_addr_d = pc_q + 32'd4;
                  pc_valid_d   = 1'b0;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
         end
         FAULT: begin
            if (trap_req) begin
               state_d    = RUN;
               epc_d      = fault_addr_q;
               pc_d       = TRAP_VEC;
               err_code_d = 2'b00;
               pc_valid_d = 1'b1;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= BOOT;
         pc_q         <= RESET_VEC;
         pc_valid_q   <= 1'b0;
         epc_q        <= 32'd0;
         fault_addr_q <= 32'd0;
         err_code_q   <= 2'b00;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc_valid_q   <= pc_valid_d;
         epc_q        <= epc_d;
         fault_addr_q <= fault_addr_d;
         err_code_q   <= err_code_d;
      end
   end

   assign pc         = pc_q;
   assign pc_valid   = pc_valid_q;
   assign epc        = epc_q;
   assign fault_addr = fault_addr_q;
   assign err_code   = err_code_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen with directed and random stimulus.
module tb_pc_gen;
   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0200;
   localparam int          DEPTH     = 256;
   localparam longint      LIMIT     = longint'(DEPTH) * 4;

   logic        clk = 1'b0;
   logic        reset, stall, redirect_valid, trap_req;
   logic [31:0] redirect_target;
   logic [31:0] pc, epc, fault_addr;
   logic        pc_valid;
   logic [1:0]  err_code;

   pc_gen #(.RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .trap_req(trap_req), .pc(pc),
      .pc_valid(pc_valid), .epc(epc), .fault_addr(fault_addr), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        v;
      logic [31:0] epc;
      logic [31:0] fa;
      logic [1:0]  err;
      int          due;
   } exp_t;

   exp_t q[$];
   int   edge_cnt = 0;
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0 boot, 1 running, 2 parked on a fault.
   int          m_mode = 0;
   longint      m_pc = 0;
   logic        m_v = 1'b0;
   logic [31:0] m_epc = 0, m_fa = 0;
   logic [1:0]  m_err = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= edge_cnt) begin
         exp_t e;
         e = q.pop_front();
         chk("pc", pc, e.pc);
         chk("pc_valid", 32'(pc_valid), 32'(e.v));
         chk("epc", epc, e.epc);
         chk("fault_addr", fault_addr, e.fa);
         chk("err_code", 32'(err_code), 32'(e.err));
      end
   end

   task automatic go_fault(input logic [1:0] code, input logic [31:0] addr);
      m_mode = 2;
      m_err  = code;
      m_fa   = addr;
      m_v    = 1'b0;
   endtask

   task automatic step(input logic r, input logic st, input logic rv, input logic [31:0] rt, input logic tr);
      exp_t e;
      reset = r; stall = st; redirect_valid = rv; redirect_target = rt; trap_req = tr;
      if (r) begin
         m_mode = 0; m_pc = longint'(RESET_VEC); m_v = 1'b0; m_epc = 0; m_fa = 0; m_err = 0;
      end else if (m_mode == 0) begin
         m_mode = 1; m_v = 1'b1;
      end else if (m_mode == 1) begin
         if (tr) begin
            m_epc = 32'(m_pc); m_pc = longint'(TRAP_VEC);
         end else if (rv) begin
            if (rt % 4 != 0) go_fault(2'b01, rt);
            else if (longint'(rt) >= LIMIT) go_fault(2'b10, rt);
            else m_pc = longint'(rt);
         end else if (!st) begin
            if (m_pc + 4 >= LIMIT) go_fault(2'b10, 32'(m_pc + 4));
            else m_pc = m_pc + 4;
         end
      end else if (tr) begin
         m_mode = 1; m_epc = m_fa; m_pc = longint'(TRAP_VEC); m_err = 0; m_v = 1'b1;
      end
      e.pc = 32'(m_pc); e.v = m_v; e.epc = m_epc; e.fa = m_fa; e.err = m_err;
      e.due = edge_cnt + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic redir(input logic [31:0] t);
      step(0, 0, 1, t, 0);
   endtask

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      idle(3);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      idle(1);
      step(0, 1, 1, 32'd44, 0);
      idle(1);
      redir(32'd1020);
      idle(2);
      step(0, 0, 0, 0, 1);
      idle(1);
      redir(32'd2);
      step(0, 1, 1, 32'd8, 0);
      step(0, 0, 0, 0, 1);
      redir(32'd4096);
      idle(1);
      step(0, 0, 0, 0, 1);
      redir(32'd4098);
      step(0, 0, 0, 0, 1);
      redir(32'd16);
      step(0, 0, 1, 32'd100, 1);
      idle(1);
      redir(32'd6);
      step(1, 0, 0, 0, 0);
      idle(3);
      for (int i = 0; i < 2000; i++) begin
         logic        r, st, rv, tr;
         logic [31:0] t;
         int          sel;
         r   = $urandom_range(0, 99) < 2;
         tr  = $urandom_range(0, 99) < 10;
         rv  = $urandom_range(0, 99) < 20;
         st  = $urandom_range(0, 99) < 30;
         sel = $urandom_range(0, 9);
         if (sel <= 5) t = 32'($urandom_range(0, DEPTH - 1)) << 2;
         else if (sel == 6) t = 32'($urandom_range(DEPTH - 6, DEPTH - 1)) << 2;
         else if (sel == 7) t = {$urandom() >> 2, 2'(32'($urandom_range(1, 3)))};
         else if (sel == 8) t = {$urandom() | 32'h8000_0000} & ~32'd3;
         else t = 32'(LIMIT) + (32'($urandom_range(0, 1)) << 1);
         step(r, st, rv, t, tr);
      end
      idle(2);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
